// File: rtl/ifu_rand_delay_unit.sv
// Fetch-side AXI timing randomiser: an LFSR drives two request-delay channels
// (AR valid, R ready), alongside a load-enabled capture register for read data.

module ifu_rdg #(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic [31:0] o_random
);

  logic [31:0] r_lfsr;
  logic        w_feedback;

  // Taps for x^32 + x^22 + x^2 + x + 1, shifted in at the LSB.
  assign w_feedback = r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {r_lfsr[30:0], w_feedback};
    end
  end

  assign o_random = r_lfsr;

  a_lfsr_nonzero: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    r_lfsr != 32'd0);

endmodule

module ifu_sdsg (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       i_signal,
  input  logic [7:0] i_delay_num,
  input  logic       i_clr,
  output logic       o_signal
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ARMED = 1'b1
  } state_t;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       w_fire;

  // A zero delay fires in the capture cycle itself, before the counter is loaded.
  assign w_fire   = (r_state == S_ARMED) ? (r_cnt == 8'd0) : (i_delay_num == 8'd0);
  assign o_signal = i_signal & w_fire;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else if (i_clr || !i_signal) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else if (r_state == S_IDLE) begin
      r_state <= S_ARMED;
      r_cnt   <= i_delay_num;
    end else if (r_cnt != 8'd0) begin
      r_cnt   <= r_cnt - 8'd1;
    end
  end

  // Once asserted the request must stay up until its handshake or until it is withdrawn.
  a_hold_until_handshake: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (o_signal && !i_clr) |=> (!i_signal || o_signal));

endmodule

module ifu_data_reg #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_data <= RESET_VAL;
    end else if (i_en) begin
      r_data <= i_data;
    end
  end

  assign o_data = r_data;

endmodule

module ifu_rand_delay_unit #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [31:0]      SEED      = 32'hACE1_2468,
  parameter bit               DELAY_EN  = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             arvalid_i,
  input  logic             arready_i,
  output logic             arvalid_o,
  input  logic             rready_i,
  input  logic             rvalid_i,
  output logic             rready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_en_i,
  output logic [WIDTH-1:0] data_o,
  output logic [31:0]      random_o
);

  logic [31:0] w_random;

  ifu_rdg #(.SEED(SEED)) u_rdg (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .o_random (w_random)
  );

  assign random_o = w_random;

  generate
    if (DELAY_EN) begin : g_delay
      logic w_ar_clr;
      logic w_r_clr;

      assign w_ar_clr = arvalid_o & arready_i;
      assign w_r_clr  = rready_o & rvalid_i;

      // The two channels tap overlapping LFSR bytes so their delays differ but stay cheap.
      ifu_sdsg u_sdsg_ar (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .i_signal    (arvalid_i),
        .i_delay_num (w_random[7:0]),
        .i_clr       (w_ar_clr),
        .o_signal    (arvalid_o)
      );

      ifu_sdsg u_sdsg_r (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .i_signal    (rready_i),
        .i_delay_num (w_random[8:1]),
        .i_clr       (w_r_clr),
        .o_signal    (rready_o)
      );
    end else begin : g_bypass
      logic w_unused;

      assign w_unused  = arready_i ^ rvalid_i;
      assign arvalid_o = arvalid_i;
      assign rready_o  = rready_i;
    end
  endgenerate

  ifu_data_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_data_reg (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .i_en    (data_en_i),
    .i_data  (data_i),
    .o_data  (data_o)
  );

endmodule

// File: tb/tb_ifu_rand_delay_unit.sv
// Randomised and directed checks of ifu_rand_delay_unit (delayed and bypass builds)
// against a timestamp-based model of the delay channels.

module tb_ifu_rand_delay_unit;

  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        arvalid_i = 1'b0, arready_i = 1'b0, rready_i = 1'b0, rvalid_i = 1'b0;
  logic        data_en_i = 1'b0;
  logic [31:0] data_i = 32'd0;

  logic        arvalid_o, rready_o, bArvalid, bRready;
  logic [31:0] data_o, random_o, bData, bRandom;

  always #5 clk_i = ~clk_i;

  ifu_rand_delay_unit dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .arvalid_i(arvalid_i), .arready_i(arready_i), .arvalid_o(arvalid_o),
    .rready_i(rready_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .data_i(data_i), .data_en_i(data_en_i), .data_o(data_o), .random_o(random_o)
  );

  ifu_rand_delay_unit #(.DELAY_EN(1'b0)) dutByp (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .arvalid_i(arvalid_i), .arready_i(arready_i), .arvalid_o(bArvalid),
    .rready_i(rready_i), .rvalid_i(rvalid_i), .rready_o(bRready),
    .data_i(data_i), .data_en_i(data_en_i), .data_o(bData), .random_o(bRandom)
  );

  int nTests = 0;
  int nFail  = 0;

  // Model: each channel remembers whether a request is pending, the cycle it was
  // captured in and the delay sampled then; the output rises once enough cycles passed.
  logic [31:0] mLfsr;
  logic [31:0] mData;
  int          cyc = 0;
  bit          aPend, rPend;
  int          aCap, rCap, aDly, rDly;
  logic        expA, expR;
  logic        lastA, lastR;
  logic [31:0] lastData;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic chanOut(input logic sig, input bit pend, input int cap,
                                   input int dly, input logic [7:0] dNow, input int now);
    if (!sig) return 1'b0;
    if (!pend) return (dNow == 8'd0);
    return (now > cap + dly);
  endfunction

  task automatic chanNext(input logic sig, input logic hs, input logic [7:0] dNow,
                          inout bit pend, inout int cap, inout int dly);
    if (hs || !sig) begin
      pend = 1'b0;
    end else if (!pend) begin
      pend = 1'b1;
      cap  = cyc;
      dly  = int'(dNow);
    end
  endtask

  task automatic modelReset();
    mLfsr = SEED;
    mData = 32'd0;
    aPend = 1'b0;
    rPend = 1'b0;
  endtask

  // One clock cycle: check at the falling edge, advance the model at the rising edge.
  task automatic stepCycle();
    logic aHs, rHs;
    @(negedge clk_i);
    expA = chanOut(arvalid_i, aPend, aCap, aDly, mLfsr[7:0], cyc);
    expR = chanOut(rready_i, rPend, rCap, rDly, mLfsr[8:1], cyc);
    data_en_i = rvalid_i & expR;
    #1;
    lastA    = arvalid_o;
    lastR    = rready_o;
    lastData = data_o;
    checkOutput("arvalid_o", {31'd0, arvalid_o}, {31'd0, expA});
    checkOutput("rready_o", {31'd0, rready_o}, {31'd0, expR});
    checkOutput("random_o", random_o, mLfsr);
    checkOutput("data_o", data_o, mData);
    checkOutput("byp_arvalid_o", {31'd0, bArvalid}, {31'd0, arvalid_i});
    checkOutput("byp_rready_o", {31'd0, bRready}, {31'd0, rready_i});
    checkOutput("byp_random_o", bRandom, mLfsr);
    checkOutput("byp_data_o", bData, mData);
    @(posedge clk_i);
    if (!rst_n_i) begin
      modelReset();
    end else begin
      aHs = expA & arready_i;
      rHs = expR & rvalid_i;
      chanNext(arvalid_i, aHs, mLfsr[7:0], aPend, aCap, aDly);
      chanNext(rready_i, rHs, mLfsr[8:1], rPend, rCap, rDly);
      if (data_en_i) mData = data_i;
      mLfsr = {mLfsr[30:0], mLfsr[31] ^ mLfsr[21] ^ mLfsr[1] ^ mLfsr[0]};
    end
    cyc++;
    #1;
  endtask

  // Idle until the model predicts the wanted delay byte for the chosen channel this cycle.
  task automatic waitDelay(input bit chanB, input logic [7:0] val);
    int n;
    n = 0;
    while (((chanB ? mLfsr[8:1] : mLfsr[7:0]) != val) && n < 4000) begin
      stepCycle();
      n++;
    end
    checkOutput("wait_delay_bound", {31'd0, n < 4000}, 32'd1);
  endtask

  task automatic measureRise(input int limit, output int rise);
    rise = -1;
    for (int k = 0; k < limit && rise < 0; k++) begin
      stepCycle();
      if (lastA) rise = k;
    end
  endtask

  task automatic applyStimulus(input int nCycles);
    for (int i = 0; i < nCycles; i++) begin
      arvalid_i = arvalid_i ? ($urandom_range(0, 31) != 0) : ($urandom_range(0, 3) == 0);
      rready_i  = rready_i  ? ($urandom_range(0, 31) != 0) : ($urandom_range(0, 3) == 0);
      arready_i = $urandom_range(0, 1) != 0;
      rvalid_i  = $urandom_range(0, 1) != 0;
      data_i    = $urandom;
      stepCycle();
      checkOutput("lfsr_nonzero", {31'd0, random_o != 32'd0}, 32'd1);
    end
  endtask

  initial begin
    int  rise;
    int  highs;
    logic [7:0] newDly;

    modelReset();
    arvalid_i = 1'b1;
    for (int i = 0; i < 4; i++) stepCycle();
    checkOutput("rst_random", random_o, 32'hACE1_2468);
    checkOutput("rst_data", data_o, 32'd0);
    checkOutput("rst_arvalid", {31'd0, arvalid_o}, 32'd0);
    checkOutput("rst_rready", {31'd0, rready_o}, 32'd0);
    arvalid_i = 1'b0;
    rst_n_i   = 1'b1;

    for (int i = 0; i < 1000; i++) begin
      stepCycle();
      checkOutput("lfsr_nonzero", {31'd0, random_o != 32'd0}, 32'd1);
    end

    // Zero delay on the R channel: ready in the capture cycle and data loaded at that edge.
    waitDelay(1'b1, 8'd0);
    rready_i = 1'b1;
    rvalid_i = 1'b1;
    data_i   = 32'h0000_0013;
    stepCycle();
    checkOutput("zero_rready", {31'd0, lastR}, 32'd1);
    rready_i = 1'b0;
    rvalid_i = 1'b0;
    stepCycle();
    checkOutput("zero_data", lastData, 32'h0000_0013);

    // Delay 5: counter loads at the end of the capture cycle and hits zero five edges later.
    arready_i = 1'b1;
    waitDelay(1'b0, 8'd5);
    arvalid_i = 1'b1;
    measureRise(20, rise);
    checkOutput("delay5_rise", rise, 32'd6);
    stepCycle();
    arvalid_i = 1'b0;
    stepCycle();

    // Hold: ready withheld for 10 cycles, output must stay up once risen.
    arready_i = 1'b0;
    waitDelay(1'b0, 8'd3);
    arvalid_i = 1'b1;
    highs = 0;
    for (int k = 0; k < 10; k++) begin
      stepCycle();
      highs += int'(lastA);
    end
    checkOutput("hold_high_cycles", highs, 32'd6);
    arready_i = 1'b1;
    stepCycle();
    checkOutput("hold_at_handshake", {31'd0, lastA}, 32'd1);
    arready_i = 1'b0;
    stepCycle();

    // Asynchronous reset while the delayed request is high.
    measureRise(300, rise);
    checkOutput("pre_reset_rise", {31'd0, rise >= 0}, 32'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    checkOutput("async_arvalid", {31'd0, arvalid_o}, 32'd0);
    checkOutput("async_random", random_o, SEED);
    checkOutput("async_data", data_o, 32'd0);
    modelReset();
    for (int i = 0; i < 3; i++) stepCycle();
    rst_n_i   = 1'b1;
    arvalid_i = 1'b0;
    stepCycle();

    // Abort: request withdrawn mid-count never produces an output; re-raise takes a fresh delay.
    waitDelay(1'b0, 8'd10);
    arvalid_i = 1'b1;
    highs = 0;
    for (int k = 0; k < 3; k++) begin
      stepCycle();
      highs += int'(lastA);
    end
    arvalid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      stepCycle();
      highs += int'(lastA);
    end
    checkOutput("abort_no_output", highs, 32'd0);
    newDly    = mLfsr[7:0];
    arvalid_i = 1'b1;
    measureRise(300, rise);
    checkOutput("rearm_rise", rise, (newDly == 8'd0) ? 32'd0 : 32'(newDly) + 32'd1);
    arready_i = 1'b1;
    stepCycle();
    arvalid_i = 1'b0;
    arready_i = 1'b0;
    stepCycle();

    applyStimulus(3000);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
